ask2_keyboard_ctrl: RTL
=======================

// Module: ask2_keyboard_ctrl
// PURPOSE
//  Avalon-MM keyboard controller for the ASK2 front-panel switches SW1..SW6 on the Nios CPU bus.
//  Synchronises and debounces the raw switch lines and detects press/release edges per key.
//  Serialises simultaneous edges into an event FIFO that the CPU pops; raises a level IRQ.
//  Replaces raw PIO polling; firmware reads events instead of sampling levels.
// PARAMETERS
//  N_KEYS          6       number of switch inputs (1..8)
//  DEBOUNCE_CYCLES 500000  stable-level cycles before an edge is accepted; must be >= N_KEYS
//  FIFO_DEPTH      8       event FIFO entries, power of two, 2..16
//  ACTIVE_LOW      1       1: in_port low = pressed
//  REPEAT_DELAY    25000000 hold cycles before first repeat (KBD_AUTOREPEAT_EN only)
//  REPEAT_PERIOD   5000000 cycles between repeats (KBD_AUTOREPEAT_EN only)
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous, active-low reset
//  address    in   2       register word address
//  chipselect in   1       slave select
//  read       in   1       read strobe (readLatency 1)
//  write      in   1       write strobe
//  writedata  in   32      write data
//  readdata   out  32      registered read data
//  in_port    in   N_KEYS  raw switch lines, asynchronous
//  irq        out  1       level interrupt
// BEHAVIOUR
//  Reset: readdata=0, irq=0, FIFO empty, overflow=0, CONTROL=0, debounced state all released.
//  Input: 2-FF synchroniser per key, reset to released level; ACTIVE_LOW inversion after sync.
//  Debounce FSM per key: REL -> CHK_PRS (sync=pressed) -> PRS after DEBOUNCE_CYCLES stable;
//   PRS -> CHK_REL -> REL likewise; any mismatch in CHK_* returns to origin, counter cleared.
//   Accepted transition sets per-key pending flag with type PRESS(1)/RELEASE(0).
//  Arbiter: one enqueue per cycle, lowest pending key index first; flag clears on enqueue.
//   RELEASE events dropped (flag cleared, no push) when CONTROL.rel_en=0.
//  Event word: [31]=valid, [9:8]=type (0 rel,1 press,2 repeat), [2:0]=key index, rest 0.
//  Registers (readdata registered from address at cycle of read; valid next cycle):
//   0 EVENT  R: head of FIFO, pops on chipselect&read; empty -> 0, no pop. W ignored.
//   1 STATUS R: [4:0] count, [5] empty, [6] overflow (sticky), [23:16] debounced key state.
//   2 CONTROL RW: [0] irq_en, [1] rel_en; W [4]=1 self-clearing flush: empty FIFO, clear overflow.
//   3 reserved, reads 0.
//  FIFO full + push without pop: event discarded, overflow=1. Push+pop same cycle at full: both
//   occur, count unchanged. Push+pop when empty: push only, read returns 0.
//  Flush same cycle as push: flush wins, event lost, overflow stays 0.
//  irq = irq_en & (!empty | overflow), registered, asserts 1 cycle after condition.
//  Reads without chipselect have no side effects; readdata still updates.
// CONFIGURATION
//  KBD_AUTOREPEAT_EN defined: while lowest-index held key stays in PRS, REPEAT event (type 2)
//   after REPEAT_DELAY, then every REPEAT_PERIOD; any key edge restarts timer. Repeat queued
//   via arbiter at lowest priority.
//  Undefined: no repeat logic, REPEAT_* unused, type 2 never produced.
// STRUCTURE
//  Package ask2_kbd_pkg: register address constants, event type enum EV_RELEASE/EV_PRESS/
//   EV_REPEAT, event field positions, STATUS/CONTROL bit positions.
//  Sub-module ask2_key_debounce: synchroniser + debounce FSM + counter, instantiated N_KEYS times.
//  Top holds pending flags, priority arbiter, FIFO, register file, irq.
// TESTING (sim override DEBOUNCE_CYCLES=1000, FIFO_DEPTH=8)
//  Reset, read all addrs -> EVENT=0, STATUS=0x0000_0020, CONTROL=0, irq=0.
//  SW on key2 bouncing every 100 cycles for 2000, then held low -> exactly one 0x8000_0102.
//  Keys 0,3,5 pressed same cycle -> count=3, pops 0x8000_0100, 0x8000_0103, 0x8000_0105.
//  irq_en=1, 9 presses with no reads -> count=8, overflow=1, irq=1; write CONTROL 0x11 -> irq=0.
//  rel_en=0: press+release key1 -> only 0x8000_0101; rel_en=1 -> also 0x8000_0001.
//  KBD_AUTOREPEAT_EN: hold key1 DELAY+3*PERIOD -> press + three 0x8000_0201; undefined -> press only.

Source files
------------

// File: rtl/ask2_kbd_pkg.sv
// Shared definitions for the ASK2 keyboard controller: register map,
// event word layout, STATUS/CONTROL bit positions and the event word builder.
// Optional feature macro used by the controller: KBD_AUTOREPEAT_EN.
package ask2_kbd_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_EVENT   = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  // Event types as they appear in the event word
  typedef enum logic [1:0] {
    EV_RELEASE = 2'd0,
    EV_PRESS   = 2'd1,
    EV_REPEAT  = 2'd2
  } ev_type_e;

  // Event word field positions
  localparam int EV_VALID_BIT = 31;
  localparam int EV_TYPE_LSB  = 8;
  localparam int EV_KEY_LSB   = 0;

  // STATUS bit positions
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY_BIT = 5;
  localparam int ST_OVF_BIT   = 6;
  localparam int ST_KEYS_LSB  = 16;

  // CONTROL bit positions
  localparam int CTL_IRQ_EN_BIT = 0;
  localparam int CTL_REL_EN_BIT = 1;
  localparam int CTL_FLUSH_BIT  = 4;

  // Compact FIFO entry; expanded to a full word only when read out
  typedef struct packed {
    ev_type_e   typ;
    logic [2:0] key;
  } ev_t;

  function automatic logic [31:0] ev_word(input ev_t ev);
    logic [31:0] w;
    w = '0;
    w[EV_VALID_BIT]       = 1'b1;
    w[EV_TYPE_LSB +: 2]   = ev.typ;
    w[EV_KEY_LSB +: 3]    = ev.key;
    return w;
  endfunction

endpackage

// File: rtl/ask2_key_debounce.sv
// One switch: 2-FF synchroniser, polarity normalisation, debounce FSM.
// Edge pulse is issued the cycle the level has been stable DEBOUNCE_CYCLES samples.
// No backpressure: the edge pulse is a single cycle and must be captured by the caller.
module ask2_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic edge_vld_o,
  output logic edge_press_o
);

  localparam int   CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic REL_RAW = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_REL, S_CHK_PRS, S_PRS, S_CHK_REL} db_state_e;

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          pressed;

  // Synchroniser and debounce next-state; the synchroniser resets to the released level
  always_comb begin
    sync1_d      = raw_i;
    sync2_d      = sync1_q;
    pressed      = sync2_q ^ REL_RAW;
    state_d      = state_q;
    cnt_d        = cnt_q;
    edge_vld_o   = 1'b0;
    edge_press_o = 1'b0;
    case (state_q)
      S_REL: begin
        if (pressed) begin
          state_d = S_CHK_PRS;
          cnt_d   = '0;
        end
      end
      S_CHK_PRS: begin
        if (!pressed) begin
          state_d = S_REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_PRS;
          cnt_d        = '0;
          edge_vld_o   = 1'b1;
          edge_press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRS: begin
        if (!pressed) begin
          state_d = S_CHK_REL;
          cnt_d   = '0;
        end
      end
      S_CHK_REL: begin
        if (pressed) begin
          state_d = S_PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_REL;
          cnt_d      = '0;
          edge_vld_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounced level: a key stays pressed while its release is still being qualified
  always_comb begin
    level_o = (state_q == S_PRS) || (state_q == S_CHK_REL);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_REL;
      cnt_q   <= '0;
      sync1_q <= REL_RAW;
      sync2_q <= REL_RAW;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

endmodule

// File: rtl/ask2_keyboard_ctrl.sv
// Avalon-MM keyboard controller: debounced key edges -> event FIFO -> CPU, level IRQ.
// Read latency 1 (readdata registered); events reach the FIFO a few cycles after debounce.
// No bus backpressure; a full FIFO discards new events and sets sticky overflow.
// Optional auto-repeat of the lowest held key is enabled by defining KBD_AUTOREPEAT_EN.
module ask2_keyboard_ctrl
  import ask2_kbd_pkg::*;
#(
  parameter int N_KEYS          = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_KEYS-1:0] in_port,
  output logic              irq
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  logic [N_KEYS-1:0] lvl, edge_vld, edge_press;
  logic [N_KEYS-1:0] pend_q, pend_d, ptype_q, ptype_d;
  logic              push_vld;
  ev_t               push_ev;

  ev_t               mem_q [FIFO_DEPTH];
  ev_t               mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              ctl_irq_en_q, ctl_irq_en_d, ctl_rel_en_q, ctl_rel_en_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              empty, full, do_pop, do_flush, wr_ctl, push_ok;
  logic              unused_wdata;

  assign unused_wdata = ^{writedata[31:5], writedata[3:2]};

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      ask2_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_db (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw_i       (in_port[gi]),
        .level_o     (lvl[gi]),
        .edge_vld_o  (edge_vld[gi]),
        .edge_press_o(edge_press[gi])
      );
    end
  endgenerate

`ifdef KBD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic          rep_pend_q, rep_pend_d;
  logic [2:0]    rep_key_q, rep_key_d;
  logic          rep_fire;
  logic [2:0]    held_key;

  // Repeat timer: restarts on any key edge, first fires after DELAY then every PERIOD
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    held_key    = 3'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (lvl[i]) held_key = 3'(i);
    end
    if ((|edge_vld) || !(|lvl)) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == (rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      rep_pend_q  <= 1'b0;
      rep_key_q   <= 3'd0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      rep_pend_q  <= rep_pend_d;
      rep_key_q   <= rep_key_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Priority arbiter: lowest pending key wins; a fresh edge re-arms its flag after the grant
  always_comb begin
    logic granted;
    granted  = 1'b0;
    pend_d   = pend_q;
    ptype_d  = ptype_q;
    push_vld = 1'b0;
    push_ev  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!granted && pend_q[i]) begin
        granted   = 1'b1;
        pend_d[i] = 1'b0;
        if (ptype_q[i] || ctl_rel_en_q) begin
          push_vld    = 1'b1;
          push_ev.typ = ptype_q[i] ? EV_PRESS : EV_RELEASE;
          push_ev.key = 3'(i);
        end
      end
    end
`ifdef KBD_AUTOREPEAT_EN
    rep_pend_d = rep_pend_q;
    rep_key_d  = rep_key_q;
    if (!granted && rep_pend_q) begin
      push_vld    = 1'b1;
      push_ev.typ = EV_REPEAT;
      push_ev.key = rep_key_q;
      rep_pend_d  = 1'b0;
    end
    if (rep_fire) begin
      rep_pend_d = 1'b1;
      rep_key_d  = held_key;
    end
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      if (edge_vld[i]) begin
        pend_d[i]  = 1'b1;
        ptype_d[i] = edge_press[i];
      end
    end
  end

  // FIFO, overflow and control next-state; flush beats a same-cycle push
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNTW'(FIFO_DEPTH));
    wr_ctl   = chipselect && write && (address == ADDR_CONTROL);
    do_flush = wr_ctl && writedata[CTL_FLUSH_BIT];
    do_pop   = chipselect && read && (address == ADDR_EVENT) && !empty;
    push_ok  = push_vld && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ctl_irq_en_d = ctl_irq_en_q;
    ctl_rel_en_d = ctl_rel_en_q;
    if (wr_ctl) begin
      ctl_irq_en_d = writedata[CTL_IRQ_EN_BIT];
      ctl_rel_en_d = writedata[CTL_REL_EN_BIT];
    end
    if (do_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_vld && !push_ok) ovf_d = 1'b1;
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_ev;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !push_ok) count_d = count_q - 1'b1;
    end
    irq_d = ctl_irq_en_q && (!empty || ovf_q);
  end

  // Read mux; readdata follows any read strobe, side effects need chipselect
  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        ADDR_EVENT:   readdata_d = empty ? 32'd0 : ev_word(mem_q[rd_ptr_q]);
        ADDR_STATUS: begin
          readdata_d = '0;
          readdata_d[ST_COUNT_LSB +: 5] = 5'(count_q);
          readdata_d[ST_EMPTY_BIT]      = empty;
          readdata_d[ST_OVF_BIT]        = ovf_q;
          readdata_d[ST_KEYS_LSB +: 8]  = 8'(lvl);
        end
        ADDR_CONTROL: begin
          readdata_d = '0;
          readdata_d[CTL_IRQ_EN_BIT] = ctl_irq_en_q;
          readdata_d[CTL_REL_EN_BIT] = ctl_rel_en_q;
        end
        default:      readdata_d = '0;
      endcase
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

  // Controller state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q       <= '0;
      ptype_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      ctl_irq_en_q <= 1'b0;
      ctl_rel_en_q <= 1'b0;
      irq_q        <= 1'b0;
      readdata_q   <= '0;
    end else begin
      pend_q       <= pend_d;
      ptype_q      <= ptype_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      ctl_irq_en_q <= ctl_irq_en_d;
      ctl_rel_en_q <= ctl_rel_en_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

endmodule
